// File: rtl/fb_arbiter.sv
// fb_arbiter -- shares one single-port, synchronous-read framebuffer RAM
// between two display read ports (VGA, LCD) and one renderer write port.
// Reads beat writes. VGA and LCD alternate when both are waiting. Read data
// returns to the granted port exactly three cycles after the grant decision.
// Compile-time option FB_ARB_STARVE_GUARD_EN: when defined, a writer that has
// waited STARVE_LIMIT cycles wins the next decision over reads. When it is
// undefined the writer only gets the RAM when no read is eligible.
module fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int DATA_W       = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              lcd_req,
    input  logic [ADDR_W-1:0] lcd_addr,
    output logic              lcd_gnt,
    output logic [DATA_W-1:0] lcd_rdata,
    output logic              lcd_rvalid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        SRC_VGA = 1'b0,
        SRC_LCD = 1'b1
    } rd_src_e;

    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("fb_arbiter: STARVE_LIMIT must be at least 1");
    end

    logic              vga_gnt_q, vga_gnt_d;
    logic              lcd_gnt_q, lcd_gnt_d;
    logic              wr_gnt_q, wr_gnt_d;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    rd_src_e           last_rd_q, last_rd_d;
    logic              rd_vld1_q, rd_vld2_q;
    rd_src_e           rd_src1_q, rd_src1_d, rd_src2_q;
    logic              vga_rvalid_q, vga_rvalid_d;
    logic              lcd_rvalid_q, lcd_rvalid_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic [DATA_W-1:0] lcd_rdata_q, lcd_rdata_d;
    logic              vga_elig, lcd_elig, wr_elig, starve_hit;

    // A requester whose grant pulse is showing this cycle is still holding its
    // request line; it must not be granted a second time for the same request.
    assign vga_elig = vga_req && !vga_gnt_q;
    assign lcd_elig = lcd_req && !lcd_gnt_q;
    assign wr_elig  = wr_req  && !wr_gnt_q;

    // Grant decision: starved writer first, then reads round-robin, then writer.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that left
        // one unassigned would infer a latch.
        vga_gnt_d = 1'b0;
        lcd_gnt_d = 1'b0;
        wr_gnt_d  = 1'b0;
        if (wr_elig && starve_hit) begin
            wr_gnt_d = 1'b1;
        end else if (vga_elig && lcd_elig) begin
            if (last_rd_q == SRC_VGA) lcd_gnt_d = 1'b1;
            else                      vga_gnt_d = 1'b1;
        end else if (vga_elig) begin
            vga_gnt_d = 1'b1;
        end else if (lcd_elig) begin
            lcd_gnt_d = 1'b1;
        end else if (wr_elig) begin
            wr_gnt_d = 1'b1;
        end
    end

    // RAM command for the winner; idle cycles keep the last address and data.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        last_rd_d   = last_rd_q;
        if (wr_gnt_d) begin
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
        end else if (vga_gnt_d) begin
            ram_addr_d = vga_addr;
            last_rd_d  = SRC_VGA;
        end else if (lcd_gnt_d) begin
            ram_addr_d = lcd_addr;
            last_rd_d  = SRC_LCD;
        end
    end

    assign rd_src1_d = lcd_gnt_d ? SRC_LCD : SRC_VGA;

    // Read return: steer RAM data to the tagged requester, hold it otherwise.
    always_comb begin
        vga_rvalid_d = rd_vld2_q && (rd_src2_q == SRC_VGA);
        lcd_rvalid_d = rd_vld2_q && (rd_src2_q == SRC_LCD);
        vga_rdata_d  = vga_rvalid_d ? ram_rdata : vga_rdata_q;
        lcd_rdata_d  = lcd_rvalid_d ? ram_rdata : lcd_rdata_q;
    end

    // Grant, RAM command and read-tag pipeline registers. Clearing the tag
    // pipeline on reset drops any read that was in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vga_gnt_q    <= 1'b0;
            lcd_gnt_q    <= 1'b0;
            wr_gnt_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            last_rd_q    <= SRC_LCD;
            rd_vld1_q    <= 1'b0;
            rd_vld2_q    <= 1'b0;
            rd_src1_q    <= SRC_VGA;
            rd_src2_q    <= SRC_VGA;
            vga_rvalid_q <= 1'b0;
            lcd_rvalid_q <= 1'b0;
            vga_rdata_q  <= '0;
            lcd_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            vga_gnt_q    <= vga_gnt_d;
            lcd_gnt_q    <= lcd_gnt_d;
            wr_gnt_q     <= wr_gnt_d;
            ram_we_q     <= wr_gnt_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            last_rd_q    <= last_rd_d;
            rd_vld1_q    <= vga_gnt_d || lcd_gnt_d;
            rd_src1_q    <= rd_src1_d;
            rd_vld2_q    <= rd_vld1_q;
            rd_src2_q    <= rd_src1_q;
            vga_rvalid_q <= vga_rvalid_d;
            lcd_rvalid_q <= lcd_rvalid_d;
            vga_rdata_q  <= vga_rdata_d;
            lcd_rdata_q  <= lcd_rdata_d;
        end
    end

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));

    // Count cycles the writer waits; saturate, clear on grant or dropped request.
    always_comb begin
        starve_d = starve_q;
        if (!wr_req || wr_gnt_d || wr_gnt_q) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    assign vga_gnt    = vga_gnt_q;
    assign lcd_gnt    = lcd_gnt_q;
    assign wr_gnt     = wr_gnt_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign vga_rvalid = vga_rvalid_q;
    assign lcd_rvalid = lcd_rvalid_q;
    assign vga_rdata  = vga_rdata_q;
    assign lcd_rdata  = lcd_rdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter -- self-checking bench for fb_arbiter with a behavioural
// synchronous-read RAM and per-port read-data scoreboards. Honours
// FB_ARB_STARVE_GUARD_EN the same way as the design.
module tb_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 4;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          vga_req = 1'b0, lcd_req = 1'b0, wr_req = 1'b0;
    logic [AW-1:0] vga_addr = '0, lcd_addr = '0, wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          vga_gnt, lcd_gnt, wr_gnt, vga_rvalid, lcd_rvalid, ram_we;
    logic [DW-1:0] vga_rdata, lcd_rdata, ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW-1:0] ram_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] mem     [logic [AW-1:0]];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    exp_t          vga_sb[$];
    exp_t          lcd_sb[$];
    exp_t          mon_e;

    logic [36:0] outs;
    assign outs = {vga_gnt, lcd_gnt, wr_gnt, vga_rvalid, lcd_rvalid, ram_we,
                   vga_rdata, lcd_rdata, ram_addr, ram_wdata};

    fb_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_gnt(lcd_gnt),
        .lcd_rdata(lcd_rdata), .lcd_rvalid(lcd_rvalid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single-port RAM, read-before-write, data one cycle after the address.
    always @(posedge clock) begin
        ram_rdata <= mem.exists(ram_addr) ? mem[ram_addr] : '0;
        if (ram_we) mem[ram_addr] = ram_wdata;
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : '0;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[a]     = d;
        exp_mem[a] = d;
    endtask

    // Scoreboard monitor: push expected data on each read grant, pop on rvalid.
    always @(negedge clock) begin
        if (reset_n) begin
            if (vga_gnt || lcd_gnt || wr_gnt || ram_we) begin
                n_checks++;
                if ($countones({vga_gnt, lcd_gnt, wr_gnt}) != 1 || ram_we !== wr_gnt) begin
                    n_fail++;
                    $display("FAIL grant_onehot: vga/lcd/wr/we=%b%b%b%b, expected one grant and we==wr_gnt",
                             vga_gnt, lcd_gnt, wr_gnt, ram_we);
                end
            end
            if (vga_gnt) begin
                n_checks++;
                if (ram_addr !== vga_addr) begin
                    n_fail++;
                    $display("FAIL vga_ram_addr: got %h, expected %h", ram_addr, vga_addr);
                end
                mon_e.data = exp_rd(vga_addr);
                mon_e.due  = cyc + 2;
                vga_sb.push_back(mon_e);
            end
            if (lcd_gnt) begin
                n_checks++;
                if (ram_addr !== lcd_addr) begin
                    n_fail++;
                    $display("FAIL lcd_ram_addr: got %h, expected %h", ram_addr, lcd_addr);
                end
                mon_e.data = exp_rd(lcd_addr);
                mon_e.due  = cyc + 2;
                lcd_sb.push_back(mon_e);
            end
            if (vga_rvalid) begin
                n_checks++;
                if (vga_sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL vga_rvalid_unexpected: got rvalid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_e = vga_sb.pop_front();
                    if (vga_rdata !== mon_e.data || cyc != mon_e.due) begin
                        n_fail++;
                        $display("FAIL vga_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                                 vga_rdata, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
            if (lcd_rvalid) begin
                n_checks++;
                if (lcd_sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL lcd_rvalid_unexpected: got rvalid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_e = lcd_sb.pop_front();
                    if (lcd_rdata !== mon_e.data || cyc != mon_e.due) begin
                        n_fail++;
                        $display("FAIL lcd_rdata: got %h at cycle %0d, expected %h at cycle %0d",
                                 lcd_rdata, cyc, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((vga_sb.size() != 0 || lcd_sb.size() != 0) && n < 12) begin
            @(posedge clock); #1;
            n++;
        end
        n_checks++;
        if (vga_sb.size() != 0 || lcd_sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d vga / %0d lcd reads outstanding, expected 0",
                     tag, vga_sb.size(), lcd_sb.size());
        end
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset_n = 1'b0;
        vga_sb.delete();
        lcd_sb.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        reset_n = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %h, expected 0", outs);
        end
    endtask

    task automatic test_single_vga();
        preload(19'h00010, 4'h7);
        @(posedge clock); #1;
        vga_addr = 19'h00010;
        vga_req  = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (vga_gnt !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 19'h00010) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b we=%b addr=%h, expected 1 0 00010",
                     vga_gnt, ram_we, ram_addr);
        end
        vga_req = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (vga_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gnt_pulse: got gnt=%b, expected 0", vga_gnt);
        end
        @(posedge clock); #1;
        n_checks++;
        if (vga_rvalid !== 1'b1 || vga_rdata !== 4'h7) begin
            n_fail++;
            $display("FAIL single_rvalid: got rvalid=%b rdata=%h, expected 1 7", vga_rvalid, vga_rdata);
        end
        @(posedge clock); #1;
        n_checks++;
        if (vga_rvalid !== 1'b0 || vga_rdata !== 4'h7) begin
            n_fail++;
            $display("FAIL single_hold: got rvalid=%b rdata=%h, expected 0 7", vga_rvalid, vga_rdata);
        end
        drain("single");
    endtask

    task automatic test_alternate();
        logic exp_v;
        preload(19'h00100, 4'h3);
        preload(19'h00200, 4'hC);
        apply_reset();
        vga_addr = 19'h00100;
        lcd_addr = 19'h00200;
        vga_req  = 1'b1;
        lcd_req  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            exp_v = (i % 2 == 0);
            n_checks++;
            if ({vga_gnt, lcd_gnt} !== {exp_v, ~exp_v}) begin
                n_fail++;
                $display("FAIL alternate_%0d: got vga/lcd=%b%b, expected %b%b",
                         i, vga_gnt, lcd_gnt, exp_v, ~exp_v);
            end
        end
        vga_req = 1'b0;
        lcd_req = 1'b0;
        drain("alternate");
    endtask

    task automatic test_write();
        bit got = 0;
        @(posedge clock); #1;
        wr_addr = 19'h12345;
        wr_data = 4'hA;
        wr_req  = 1'b1;
        exp_mem[19'h12345] = 4'hA;
        @(posedge clock); #1;
        n_checks++;
        if (wr_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 19'h12345 || ram_wdata !== 4'hA) begin
            n_fail++;
            $display("FAIL write_issue: got gnt=%b we=%b addr=%h data=%h, expected 1 1 12345 a",
                     wr_gnt, ram_we, ram_addr, ram_wdata);
        end
        wr_req = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (wr_gnt !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 19'h12345) begin
            n_fail++;
            $display("FAIL write_one_cycle: got gnt=%b we=%b addr=%h, expected 0 0 12345",
                     wr_gnt, ram_we, ram_addr);
        end
        lcd_addr = 19'h12345;
        lcd_req  = 1'b1;
        for (int i = 0; i < 5 && lcd_req; i++) begin
            @(posedge clock); #1;
            if (lcd_gnt) lcd_req = 1'b0;
        end
        lcd_req = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge clock); #1;
            if (lcd_rvalid) got = 1;
        end
        n_checks++;
        if (!got || lcd_rdata !== 4'hA) begin
            n_fail++;
            $display("FAIL write_readback: got rvalid_seen=%0d rdata=%h, expected 1 a", got, lcd_rdata);
        end
        drain("write");
    endtask

    task automatic test_starve();
        bit got = 0;
        int k = 0;
        vga_addr = 19'h00100;
        lcd_addr = 19'h00200;
        @(posedge clock); #1;
        wr_addr  = 19'h00777;
        wr_data  = 4'h5;
        exp_mem[19'h00777] = 4'h5;
        vga_req  = 1'b1;
        lcd_req  = 1'b1;
        wr_req   = 1'b1;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(posedge clock); #1;
            if (wr_gnt) begin
                got = 1;
                k   = i;
                wr_req = 1'b0;
                n_checks++;
                if (ram_we !== 1'b1 || ram_addr !== 19'h00777 || ram_wdata !== 4'h5) begin
                    n_fail++;
                    $display("FAIL starve_write: got we=%b addr=%h data=%h, expected 1 00777 5",
                             ram_we, ram_addr, ram_wdata);
                end
            end
        end
`ifdef FB_ARB_STARVE_GUARD_EN
        n_checks++;
        if (!got || k > 17) begin
            n_fail++;
            $display("FAIL starve_guard: got wr_gnt=%0d after %0d cycles, expected grant within 17", got, k);
        end
`else
        n_checks++;
        if (got) begin
            n_fail++;
            $display("FAIL starve_noguard: got wr_gnt after %0d cycles, expected none in 100", k);
        end
`endif
        vga_req = 1'b0;
        lcd_req = 1'b0;
        for (int i = 0; i < 10 && wr_req; i++) begin
            @(posedge clock); #1;
            if (wr_gnt) begin
                got = 1;
                wr_req = 1'b0;
            end
        end
        wr_req = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL starve_final_write: got no wr_gnt, expected one once reads stop");
        end
        drain("starve");
    endtask

    task automatic test_reset_midflight();
        int cnt = 0;
        @(posedge clock); #1;
        vga_addr = 19'h00010;
        vga_req  = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (vga_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_grant: got gnt=%b, expected 1", vga_gnt);
        end
        vga_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL midflight_async_reset: got %h, expected 0", outs);
        end
        vga_sb.delete();
        lcd_sb.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
            if (vga_rvalid) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL midflight_no_rvalid: got %0d rvalid pulses, expected 0", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_vga();
        test_alternate();
        test_write();
        test_starve();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by time 100000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, framebuffer address width.
REQ-002 SHALL have parameter DATA_W, default 4, pixel (palette index) width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15, writer wait cycles before forced grant.
REQ-004 clock  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 vga_req  input  1  VGA read request, level, held until vga_gnt.
REQ-007 vga_addr  input  ADDR_W  VGA read address, stable while vga_req high.
REQ-008 vga_gnt  output  1  one-cycle VGA grant pulse.
REQ-009 vga_rdata  output  DATA_W  VGA read data.
REQ-010 vga_rvalid  output  1  one-cycle pulse, vga_rdata valid.
REQ-011 lcd_req  input  1  LCD read request, same rules as vga_req.
REQ-012 lcd_addr  input  ADDR_W  LCD read address.
REQ-013 lcd_gnt  output  1  one-cycle LCD grant pulse.
REQ-014 lcd_rdata  output  DATA_W  LCD read data.
REQ-015 lcd_rvalid  output  1  one-cycle pulse, lcd_rdata valid.
REQ-016 wr_req  input  1  renderer write request, held until wr_gnt.
REQ-017 wr_addr  input  ADDR_W  write address.
REQ-018 wr_data  input  DATA_W  write data.
REQ-019 wr_gnt  output  1  one-cycle pulse, write issued to RAM.
REQ-020 ram_addr  output  ADDR_W  single-port RAM address, registered.
REQ-021 ram_we  output  1  RAM write enable, registered.
REQ-022 ram_wdata  output  DATA_W  RAM write data, registered.
REQ-023 ram_rdata  input  DATA_W  RAM read data, valid one cycle after ram_addr (synchronous read).

Function
REQ-024 SHALL make at most one grant decision per cycle t; winner's gnt, ram_addr, ram_we, ram_wdata registered and visible in cycle t+1.
REQ-025 SHALL exclude from decision in cycle t any requester whose gnt is high in cycle t (no double grant of a held request).
REQ-026 Priority: reads over writes; VGA vs LCD round-robin via last_rd pointer -- both requesting grants the one not last granted; pointer updates on every read grant.
REQ-027 Writer granted only when no eligible read request, unless starvation override (REQ-029).
REQ-028 Idle cycle (no grant): ram_we=0, ram_addr holds previous value.
REQ-029 Starve counter increments each cycle wr_req=1 and wr_gnt not issued, saturates at STARVE_LIMIT; at STARVE_LIMIT writer wins next decision over reads; counter clears on writer grant or wr_req=0.
REQ-030 Read granted in t: ram_rdata sampled in t+2, registered to that requester's rdata with rvalid pulse in t+3 (fixed latency 3 from decision).
REQ-031 x_rdata SHALL hold last value between rvalid pulses.
REQ-032 Read pipeline tags requester; back-to-back VGA then LCD grants yield rvalid pulses in consecutive cycles, no crosstalk.
REQ-033 Write grant SHALL assert ram_we for exactly one cycle with wr_addr/wr_data captured at decision.

Reset
REQ-034 reset_n low: all gnt, rvalid, ram_we=0; rdata, ram_addr, ram_wdata=0; last_rd=LCD (VGA first); starve counter=0.
REQ-035 Reset mid-operation discards in-flight reads: no rvalid after reset_n deasserts for reads granted before reset.

Configuration
REQ-036 Macro FB_ARB_STARVE_GUARD_EN defined: REQ-029 override active.
REQ-037 Macro undefined: no counter, writer strictly lowest priority, may starve indefinitely.

Verification
REQ-038 Only vga_req, addr 0x00010, RAM holds 0x7 -> vga_gnt t+1, ram_we=0, vga_rvalid t+3 with vga_rdata=0x7.
REQ-039 vga_req and lcd_req held continuously -> grants alternate VGA, LCD, VGA, LCD; VGA first after reset.
REQ-040 wr_req addr 0x12345 data 0xA, no reads -> wr_gnt and ram_we one cycle, ram_addr=0x12345, ram_wdata=0xA; readback returns 0xA.
REQ-041 Guard defined, reads saturating, wr_req held -> wr_gnt within STARVE_LIMIT+2 cycles (17); guard undefined -> no wr_gnt in 100 cycles.
REQ-042 Reset asserted cycle after vga grant -> all outputs 0 asynchronously, no vga_rvalid after release.
